mem_request_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/rr_picker2.sv | 22 ++
 rtl/mem_request_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_request_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the memory request arbiter and its memory-controller side.
package mem_arb_pkg;

  localparam int ADDR_W   = 64;
  localparam int BLOCK_W  = 256;
  localparam int OFFSET_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ENGAGE,
    ST_WAIT_DONE,
    ST_RESPOND
  } state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

endpackage

// File: rtl/rr_picker2.sv
// Two-way round-robin pick between icache and dcache requests.
module rr_picker2
  import mem_arb_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
  input  grant_t last_grant,
  output logic   pick_vld,
  output grant_t pick
);

  // On a tie the side not served last wins; otherwise the lone requester wins.
  always_comb begin
    pick_vld = i_req | d_req;
    pick     = GRANT_I;
    if (i_req && d_req)
      pick = (last_grant == GRANT_I) ? GRANT_D : GRANT_I;
    else if (d_req)
      pick = GRANT_D;
  end

endmodule

// File: rtl/mem_request_arbiter.sv
// Single-outstanding arbiter from icache/dcache miss paths onto the memory controller port.
module mem_request_arbiter
  import mem_arb_pkg::*;
#(
  parameter int addressSize   = ADDR_W,
  parameter int blockSize     = BLOCK_W,
  parameter int offsetSize    = OFFSET_W,
  parameter int timeoutCycles = 1024
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   iReq_i,
  input  logic [addressSize-1:0] iAddress_i,
  output logic                   iReady_o,
  output logic [blockSize-1:0]   iBlock_o,
  output logic [addressSize-1:0] iBlockAddress_o,
  output logic                   iBlockValid_o,
  input  logic                   dReq_i,
  input  logic [addressSize-1:0] dAddress_i,
  input  logic [blockSize-1:0]   dData_i,
  input  logic                   dIsWrite_i,
  output logic                   dReady_o,
  output logic [blockSize-1:0]   dBlock_o,
  output logic [addressSize-1:0] dBlockAddress_o,
  output logic                   dBlockValid_o,
  output logic                   dWriteDone_o,
  output logic [addressSize-1:0] mcuAddress_o,
  output logic [blockSize-1:0]   mcuData_o,
  output logic                   mcuIsWrite_o,
  output logic                   mcuRequestEnable_o,
  input  logic [blockSize-1:0]   mcuBlock_i,
  input  logic [addressSize-1:0] mcuBlockAddress_i,
  input  logic                   mcuBlockOutEnable_i,
  input  logic                   mcuMemoryEngaged_i,
  output logic                   timeoutError_o
);

  // One spare bit so the count can pass the last value when engage lands on expiry.
  localparam int CNT_W = $clog2(timeoutCycles) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(timeoutCycles - 1);
  localparam logic [addressSize-1:0] OFF_MASK = addressSize'((64'd1 << offsetSize) - 64'd1);

  state_t                 state_q, state_d;
  grant_t                 last_q, last_d;
  grant_t                 gnt_q, gnt_d;
  logic [addressSize-1:0] addr_q, addr_d;
  logic [blockSize-1:0]   data_q, data_d;
  logic                   wr_q, wr_d;
  logic [blockSize-1:0]   block_q, block_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   err_q, err_d;

  logic   pick_vld;
  grant_t pick;
  logic   addr_hit;
  logic   expire;

  rr_picker2 u_pick (
    .i_req      (iReq_i),
    .d_req      (dReq_i),
    .last_grant (last_q),
    .pick_vld   (pick_vld),
    .pick       (pick)
  );

  // Block-address compare ignores the byte offset within the block.
  assign addr_hit = (((mcuBlockAddress_i ^ addr_q) & ~OFF_MASK) == '0);
  assign expire   = (cnt_q >= CNT_LAST);

  // Next-state, latches and timeout; completion is checked before expiry so it wins.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_d    = wr_q;
    block_d = block_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (!mcuMemoryEngaged_i && pick_vld) begin
          gnt_d   = pick;
          addr_d  = (pick == GRANT_D) ? dAddress_i : iAddress_i;
          data_d  = (pick == GRANT_D) ? dData_i : '0;
          wr_d    = (pick == GRANT_D) && dIsWrite_i;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT_ENGAGE;
      end
      ST_WAIT_ENGAGE: begin
        if (mcuMemoryEngaged_i) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = ST_WAIT_DONE;
        end else if (expire) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (wr_q ? !mcuMemoryEngaged_i : (mcuBlockOutEnable_i && addr_hit)) begin
          if (!wr_q) block_d = mcuBlock_i;
          state_d = ST_RESPOND;
        end else if (expire) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESPOND: begin
        last_d  = gnt_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and latch registers; reset drops any in-flight request.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      last_q  <= GRANT_I;
      gnt_q   <= GRANT_I;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      block_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      block_q <= block_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign mcuRequestEnable_o = (state_q == ST_ISSUE);
  assign iReady_o           = (state_q == ST_ISSUE) && (gnt_q == GRANT_I);
  assign dReady_o           = (state_q == ST_ISSUE) && (gnt_q == GRANT_D);
  assign mcuAddress_o       = addr_q;
  assign mcuData_o          = data_q;
  assign mcuIsWrite_o       = wr_q;

  assign iBlockValid_o   = (state_q == ST_RESPOND) && (gnt_q == GRANT_I);
  assign dBlockValid_o   = (state_q == ST_RESPOND) && (gnt_q == GRANT_D) && !wr_q;
  assign dWriteDone_o    = (state_q == ST_RESPOND) && (gnt_q == GRANT_D) && wr_q;
  assign iBlock_o        = block_q;
  assign dBlock_o        = block_q;
  assign iBlockAddress_o = addr_q;
  assign dBlockAddress_o = addr_q;
  assign timeoutError_o  = err_q;

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Directed bench for mem_request_arbiter; inputs change and outputs are sampled 1ns after posedge.
module tb_mem_request_arbiter;

  localparam int AW = 64;
  localparam int BW = 256;

  logic          clock_i = 1'b0;
  logic          reset_i;
  logic          iReq_i;
  logic [AW-1:0] iAddress_i;
  logic          iReady_o;
  logic [BW-1:0] iBlock_o;
  logic [AW-1:0] iBlockAddress_o;
  logic          iBlockValid_o;
  logic          dReq_i;
  logic [AW-1:0] dAddress_i;
  logic [BW-1:0] dData_i;
  logic          dIsWrite_i;
  logic          dReady_o;
  logic [BW-1:0] dBlock_o;
  logic [AW-1:0] dBlockAddress_o;
  logic          dBlockValid_o;
  logic          dWriteDone_o;
  logic [AW-1:0] mcuAddress_o;
  logic [BW-1:0] mcuData_o;
  logic          mcuIsWrite_o;
  logic          mcuRequestEnable_o;
  logic [BW-1:0] mcuBlock_i;
  logic [AW-1:0] mcuBlockAddress_i;
  logic          mcuBlockOutEnable_i;
  logic          mcuMemoryEngaged_i;
  logic          timeoutError_o;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  logic [BW-1:0] blk_a5, blk_d, blk_i, blk_bad, blk_ok, pat_wr;

  always #5 clock_i = ~clock_i;

  mem_request_arbiter #(
    .addressSize(AW), .blockSize(BW), .offsetSize(5), .timeoutCycles(16)
  ) dut (
    .clock_i(clock_i), .reset_i(reset_i),
    .iReq_i(iReq_i), .iAddress_i(iAddress_i), .iReady_o(iReady_o),
    .iBlock_o(iBlock_o), .iBlockAddress_o(iBlockAddress_o), .iBlockValid_o(iBlockValid_o),
    .dReq_i(dReq_i), .dAddress_i(dAddress_i), .dData_i(dData_i), .dIsWrite_i(dIsWrite_i),
    .dReady_o(dReady_o), .dBlock_o(dBlock_o), .dBlockAddress_o(dBlockAddress_o),
    .dBlockValid_o(dBlockValid_o), .dWriteDone_o(dWriteDone_o),
    .mcuAddress_o(mcuAddress_o), .mcuData_o(mcuData_o), .mcuIsWrite_o(mcuIsWrite_o),
    .mcuRequestEnable_o(mcuRequestEnable_o), .mcuBlock_i(mcuBlock_i),
    .mcuBlockAddress_i(mcuBlockAddress_i), .mcuBlockOutEnable_i(mcuBlockOutEnable_i),
    .mcuMemoryEngaged_i(mcuMemoryEngaged_i), .timeoutError_o(timeoutError_o)
  );

  task automatic cyc();
    @(posedge clock_i);
    #1;
  endtask

  // From the ISSUE cycle: engage, return a block for addr, end in the RESPOND cycle.
  task automatic mem_read_return(input logic [AW-1:0] addr, input logic [BW-1:0] blk);
    mcuMemoryEngaged_i = 1'b1;
    cyc();
    cyc();
    mcuBlockOutEnable_i = 1'b1;
    mcuBlockAddress_i   = addr;
    mcuBlock_i          = blk;
    cyc();
    mcuBlockOutEnable_i = 1'b0;
    mcuMemoryEngaged_i  = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    iReq_i = 0; iAddress_i = '0; dReq_i = 0; dAddress_i = '0; dData_i = '0; dIsWrite_i = 0;
    mcuBlock_i = '0; mcuBlockAddress_i = '0; mcuBlockOutEnable_i = 0; mcuMemoryEngaged_i = 0;
    cyc();
    cyc();
    tot_cnt++;
    if ({iReady_o, dReady_o, mcuRequestEnable_o, iBlockValid_o, dBlockValid_o, dWriteDone_o,
         mcuIsWrite_o, timeoutError_o} !== 8'h00)
      $display("FAIL reset_flags got=%b exp=0", {iReady_o, dReady_o, mcuRequestEnable_o,
               iBlockValid_o, dBlockValid_o, dWriteDone_o, mcuIsWrite_o, timeoutError_o});
    else pass_cnt++;
    tot_cnt++;
    if ((mcuAddress_o | iBlockAddress_o) !== '0 || (mcuData_o | iBlock_o | dBlock_o) !== '0)
      $display("FAIL reset_buses addr=%h data=%h exp=0", mcuAddress_o, mcuData_o);
    else pass_cnt++;
    reset_i = 1'b0;
  endtask

  task automatic test_single_read();
    iReq_i = 1; iAddress_i = 64'h1000;
    cyc();
    tot_cnt++;
    if ({iReady_o, mcuRequestEnable_o, dReady_o, mcuIsWrite_o} !== 4'b1100)
      $display("FAIL rd_issue got=%b exp=1100", {iReady_o, mcuRequestEnable_o, dReady_o, mcuIsWrite_o});
    else pass_cnt++;
    tot_cnt++;
    if (mcuAddress_o !== 64'h1000) $display("FAIL rd_addr got=%h exp=1000", mcuAddress_o);
    else pass_cnt++;
    iReq_i = 0;
    mem_read_return(64'h1000, blk_a5);
    tot_cnt++;
    if ({iBlockValid_o, dBlockValid_o} !== 2'b10 || iBlock_o !== blk_a5 || iBlockAddress_o !== 64'h1000)
      $display("FAIL rd_return v=%b blk=%h addr=%h exp v=10 blk=%h addr=1000",
               {iBlockValid_o, dBlockValid_o}, iBlock_o, iBlockAddress_o, blk_a5);
    else pass_cnt++;
    cyc();
    tot_cnt++;
    if (iBlockValid_o !== 1'b0) $display("FAIL rd_valid_pulse got=%b exp=0", iBlockValid_o);
    else pass_cnt++;
  endtask

  task automatic test_tie();
    reset_i = 1; cyc(); reset_i = 0;
    iReq_i = 1; iAddress_i = 64'h1000;
    dReq_i = 1; dAddress_i = 64'h2000; dIsWrite_i = 0;
    cyc();
    tot_cnt++;
    if ({dReady_o, iReady_o} !== 2'b10 || mcuAddress_o !== 64'h2000)
      $display("FAIL tie1_d_first rdy(d,i)=%b addr=%h exp 10 2000", {dReady_o, iReady_o}, mcuAddress_o);
    else pass_cnt++;
    mem_read_return(64'h2000, blk_d);
    tot_cnt++;
    if (dBlockValid_o !== 1'b1 || dBlock_o !== blk_d || iBlockValid_o !== 1'b0)
      $display("FAIL tie1_d_return dv=%b iv=%b blk=%h exp dv=1 iv=0", dBlockValid_o, iBlockValid_o, dBlock_o);
    else pass_cnt++;
    cyc();
    cyc();
    tot_cnt++;
    if ({dReady_o, iReady_o} !== 2'b01 || mcuAddress_o !== 64'h1000)
      $display("FAIL tie2_i_wins rdy(d,i)=%b addr=%h exp 01 1000", {dReady_o, iReady_o}, mcuAddress_o);
    else pass_cnt++;
    iReq_i = 0;
    mem_read_return(64'h1000, blk_i);
    tot_cnt++;
    if (iBlockValid_o !== 1'b1 || iBlock_o !== blk_i)
      $display("FAIL tie2_i_return v=%b blk=%h exp v=1 blk=%h", iBlockValid_o, iBlock_o, blk_i);
    else pass_cnt++;
    cyc();
    cyc();
    tot_cnt++;
    if ({dReady_o, iReady_o} !== 2'b10) $display("FAIL tie3_d_again rdy(d,i)=%b exp 10", {dReady_o, iReady_o});
    else pass_cnt++;
    dReq_i = 0;
    mem_read_return(64'h2000, blk_d);
    cyc();
  endtask

  task automatic test_write();
    dReq_i = 1; dIsWrite_i = 1; dData_i = pat_wr; dAddress_i = 64'h2040;
    cyc();
    tot_cnt++;
    if (dReady_o !== 1'b1 || mcuIsWrite_o !== 1'b1 || mcuData_o !== pat_wr || mcuAddress_o !== 64'h2040)
      $display("FAIL wr_issue rdy=%b wr=%b data=%h addr=%h exp 1 1 %h 2040",
               dReady_o, mcuIsWrite_o, mcuData_o, mcuAddress_o, pat_wr);
    else pass_cnt++;
    dReq_i = 0; dIsWrite_i = 0; dData_i = '0;
    mcuMemoryEngaged_i = 1;
    cyc();
    cyc();
    cyc();
    tot_cnt++;
    if (dWriteDone_o !== 1'b0 || mcuData_o !== pat_wr)
      $display("FAIL wr_busy done=%b data=%h exp done=0 data=%h", dWriteDone_o, mcuData_o, pat_wr);
    else pass_cnt++;
    mcuMemoryEngaged_i = 0;
    cyc();
    tot_cnt++;
    if ({dWriteDone_o, dBlockValid_o, iBlockValid_o} !== 3'b100)
      $display("FAIL wr_done got(done,dv,iv)=%b exp 100", {dWriteDone_o, dBlockValid_o, iBlockValid_o});
    else pass_cnt++;
    cyc();
    tot_cnt++;
    if (dWriteDone_o !== 1'b0) $display("FAIL wr_done_pulse got=%b exp=0", dWriteDone_o);
    else pass_cnt++;
  endtask

  task automatic test_addr_mismatch();
    iReq_i = 1; iAddress_i = 64'h1000;
    cyc();
    iReq_i = 0;
    mcuMemoryEngaged_i = 1;
    cyc();
    cyc();
    mcuBlockOutEnable_i = 1; mcuBlockAddress_i = 64'h3000; mcuBlock_i = blk_bad;
    cyc();
    tot_cnt++;
    if (iBlockValid_o !== 1'b0) $display("FAIL mm_ignored got=%b exp=0", iBlockValid_o);
    else pass_cnt++;
    mcuBlockAddress_i = 64'h101F; mcuBlock_i = blk_ok;
    cyc();
    tot_cnt++;
    if (iBlockValid_o !== 1'b1 || iBlock_o !== blk_ok || iBlockAddress_o !== 64'h1000)
      $display("FAIL mm_offset_hit v=%b blk=%h addr=%h exp 1 %h 1000", iBlockValid_o, iBlock_o,
               iBlockAddress_o, blk_ok);
    else pass_cnt++;
    mcuBlockOutEnable_i = 0; mcuMemoryEngaged_i = 0;
    cyc();
  endtask

  task automatic test_timeout();
    logic saw_valid;
    saw_valid = 1'b0;
    iReq_i = 1; iAddress_i = 64'h4000;
    cyc();
    iReq_i = 0;
    cyc();                       // now in WAIT_ENGAGE
    for (int k = 0; k < 15; k++) begin
      cyc();
      saw_valid |= iBlockValid_o | dBlockValid_o | dWriteDone_o;
    end
    tot_cnt++;
    if (timeoutError_o !== 1'b0) $display("FAIL to_early got=%b exp=0 after 15", timeoutError_o);
    else pass_cnt++;
    cyc();
    saw_valid |= iBlockValid_o | dBlockValid_o | dWriteDone_o;
    tot_cnt++;
    if (timeoutError_o !== 1'b1) $display("FAIL to_set got=%b exp=1 after 16", timeoutError_o);
    else pass_cnt++;
    tot_cnt++;
    if (saw_valid !== 1'b0) $display("FAIL to_no_resp got=%b exp=0", saw_valid);
    else pass_cnt++;
    iReq_i = 1; iAddress_i = 64'h4400;
    cyc();
    tot_cnt++;
    if (iReady_o !== 1'b1 || timeoutError_o !== 1'b1)
      $display("FAIL to_idle_sticky rdy=%b err=%b exp 1 1", iReady_o, timeoutError_o);
    else pass_cnt++;
    iReq_i = 0;
    reset_i = 1;
    cyc();
    reset_i = 0;
    tot_cnt++;
    if (timeoutError_o !== 1'b0) $display("FAIL to_reset_clears got=%b exp=0", timeoutError_o);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_read();
    iReq_i = 1; iAddress_i = 64'h5000;
    cyc();
    iReq_i = 0;
    mcuMemoryEngaged_i = 1;
    cyc();
    cyc();                       // WAIT_DONE
    reset_i = 1;
    cyc();
    reset_i = 0;
    tot_cnt++;
    if ({iReady_o, mcuRequestEnable_o, iBlockValid_o, mcuIsWrite_o, timeoutError_o} !== 5'b0 ||
        mcuAddress_o !== '0 || mcuData_o !== '0 || iBlock_o !== '0 || iBlockAddress_o !== '0)
      $display("FAIL rst_mid_outputs flags=%b addr=%h exp 0", {iReady_o, mcuRequestEnable_o,
               iBlockValid_o, mcuIsWrite_o, timeoutError_o}, mcuAddress_o);
    else pass_cnt++;
    mcuBlockOutEnable_i = 1; mcuBlockAddress_i = 64'h5000; mcuBlock_i = blk_a5;
    cyc();
    tot_cnt++;
    if (iBlockValid_o !== 1'b0 || iBlock_o !== '0) $display("FAIL rst_late_block1 v=%b exp=0", iBlockValid_o);
    else pass_cnt++;
    mcuBlockOutEnable_i = 0; mcuMemoryEngaged_i = 0;
    cyc();
    tot_cnt++;
    if (iBlockValid_o !== 1'b0) $display("FAIL rst_late_block2 v=%b exp=0", iBlockValid_o);
    else pass_cnt++;
  endtask

  initial begin
    blk_a5  = {32{8'hA5}};
    blk_d   = {8{32'h0D0D_1234}};
    blk_i   = {8{32'h1111_7777}};
    blk_bad = {8{32'hBAD0_BAD0}};
    blk_ok  = {8{32'h600D_C0DE}};
    pat_wr  = {8{32'hDEAD_BEEF}};
    test_reset();
    test_single_read();
    test_tie();
    test_write();
    test_addr_mismatch();
    test_timeout();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
